// File: rtl/aes_key_sched_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched_seq
//  Description : Iterative AES key expansion, one word per clock, with a
//                registered 128-bit round-key read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_seq #(
   parameter int NK = 4,
   parameter int NR = NK + 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_key_valid,
   output logic              o_key_ready,
   input  logic [32*NK-1:0]  i_key,
   output logic              o_busy,
   output logic              o_sched_valid,
   input  logic              i_rk_rd_en,
   input  logic [3:0]        i_rk_idx,
   output logic [127:0]      o_rk_data,
   output logic              o_rk_rd_valid
);

   localparam int         c_NW     = 4 * (NR + 1);
   localparam logic [5:0] c_LAST   = 6'(c_NW - 1);
   localparam logic [5:0] c_NK6    = 6'(NK);
   localparam logic [2:0] c_MODMAX = 3'(NK - 1);
   localparam logic [3:0] c_NR4    = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t       r_state;
   logic [5:0]   r_i;
   logic [2:0]   r_mod;
   logic [3:0]   r_rc;
   logic         r_busy;
   logic         r_sched_valid;
   logic         r_rk_rd_valid;
   logic [127:0] r_rk_data;

   logic [31:0]  w_words [c_NW];
   logic         w_accept;
   logic         w_expand;
   logic [31:0]  w_prev;
   logic [31:0]  w_back;
   logic [31:0]  w_sub;
   logic [31:0]  w_tmp;
   logic [31:0]  w_new;
   logic [3:0]   w_rd_idx;
   logic         w_rd_hit;
   logic [127:0] w_rd_key;

   function automatic logic [7:0] f_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = f_xtime(x);
      end
      return p;
   endfunction

   // S-box = affine(x^254); x^254 = x^2 * x^4 * ... * x^128, with 0 -> 0
   function automatic logic [7:0] f_sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int n = 1; n < 8; n++) begin
         sq  = f_gmul(sq, sq);
         inv = f_gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] f_subword(input logic [31:0] w);
      return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
   endfunction

   // Byte 0 of a word sits in bits [7:0], so the rotation moves it to the top
   function automatic logic [31:0] f_rotword(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

   function automatic logic [7:0] f_rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign o_key_ready = (r_state != S_EXPAND) && !rst;
   assign w_accept    = i_key_valid && o_key_ready;
   assign w_expand    = (r_state == S_EXPAND);

   always_comb begin
      w_prev = w_words[r_i - 6'd1];
      w_back = w_words[r_i - c_NK6];
      w_sub  = f_subword((r_mod == 3'd0) ? f_rotword(w_prev) : w_prev);
      if (r_mod == 3'd0)
         w_tmp = w_sub ^ {24'h0, f_rcon(r_rc)};
      else if ((NK > 6) && (r_mod == 3'd4))
         w_tmp = w_sub;
      else
         w_tmp = w_prev;
      w_new = w_back ^ w_tmp;
   end

   for (genvar g = 0; g < c_NW; g++) begin : g_word
      logic [31:0] r_word;
      if (g < NK) begin : g_key
         always_ff @(posedge clk) begin
            if (w_accept) r_word <= i_key[32*g +: 32];
         end
      end else begin : g_exp
         always_ff @(posedge clk) begin
            if (w_expand && (r_i == 6'(g))) r_word <= w_new;
         end
      end
      assign w_words[g] = r_word;
   end

   assign w_rd_idx = (i_rk_idx > c_NR4) ? 4'd0 : i_rk_idx;
   assign w_rd_hit = r_sched_valid && (i_rk_idx <= c_NR4);
   assign w_rd_key = {w_words[{w_rd_idx, 2'b11}], w_words[{w_rd_idx, 2'b10}],
                      w_words[{w_rd_idx, 2'b01}], w_words[{w_rd_idx, 2'b00}]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_i           <= 6'd0;
         r_mod         <= 3'd0;
         r_rc          <= 4'd0;
         r_busy        <= 1'b0;
         r_sched_valid <= 1'b0;
         r_rk_rd_valid <= 1'b0;
         r_rk_data     <= '0;
      end else begin
         r_rk_rd_valid <= i_rk_rd_en;
         // Read samples the pre-edge schedule, so a read beside a rekey sees the old key
         if (i_rk_rd_en) r_rk_data <= w_rd_hit ? w_rd_key : '0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_key_valid) begin
                  r_i           <= c_NK6;
                  r_mod         <= 3'd0;
                  r_rc          <= 4'd1;
                  r_busy        <= 1'b1;
                  r_sched_valid <= 1'b0;
                  r_state       <= S_EXPAND;
               end
            end
            S_EXPAND: begin
               r_i <= r_i + 6'd1;
               if (r_mod == c_MODMAX) begin
                  r_mod <= 3'd0;
                  r_rc  <= r_rc + 4'd1;
               end else begin
                  r_mod <= r_mod + 3'd1;
               end
               if (r_i == c_LAST) begin
                  r_busy        <= 1'b0;
                  r_sched_valid <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_sched_valid = r_sched_valid;
   assign o_rk_data     = r_rk_data;
   assign o_rk_rd_valid = r_rk_rd_valid;

endmodule
`default_nettype wire
